// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: register offsets, CTRL/STATUS
// bit positions and the state encodings of the AXI and ramp state machines.
package pwm_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_TARGET = 8'h04;
    localparam logic [7:0] ADDR_STEP   = 8'h08;
    localparam logic [7:0] ADDR_PERIOD = 8'h0C;
    localparam logic [7:0] ADDR_STATUS = 8'h10;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_DUTY_LSB = 8;

    typedef enum logic [1:0] {
        WRIDLE = 2'd0,
        WRDATA = 2'd1,
        WRRESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        RDIDLE = 1'b0,
        RDDATA = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/pwm_core.sv
// Free-running 8-bit PWM generator: the output is high for pwm_value of
// every 256 clock cycles.
module pwm_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pwm_value,
    output logic       pwm_out
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= 8'd0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 8'd1;
            pwm_out <= (cnt < pwm_value);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// AXI4-lite controlled PWM duty ramp generator. Optional ramp-done interrupt
// is compiled in when PWM_RAMP_IRQ_EN is defined.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int C_ADDR_BITS  = 8,
    parameter int C_RESET_DUTY = 50
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        pwm_out,
    output logic        irq
);

    wr_state_t              wstate, wstate_next;
    rd_state_t              rstate, rstate_next;
    ramp_state_t            state, state_next;
    logic [C_ADDR_BITS-1:0] waddr, raddr;
    logic                   wr_en, sel_ctrl, start_req, abort_req, do_start, clr_done;
    logic [7:0]             cfg_target, cfg_step, lat_target, lat_step, duty, duty_stepped;
    logic [15:0]            cfg_period, lat_period, presc;
    logic                   busy, done, step_fire, done_set;
    logic [31:0]            rd_mux;
    logic                   unused_bits;
`ifdef PWM_RAMP_IRQ_EN
    logic                   irq_en;
`endif

    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata[31:16], s_axi_wstrb[3:2]};

    // Saturating move of cur toward tgt; a zero step still advances by one.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                               input logic [7:0] stp);
        logic [7:0] inc, gap;
        inc = (stp == 8'd0) ? 8'd1 : stp;
        if (tgt >= cur) begin
            gap = tgt - cur;
            return (gap < inc) ? tgt : cur + inc;
        end
        gap = cur - tgt;
        return (gap < inc) ? tgt : cur - inc;
    endfunction

    function automatic logic hit(input logic [C_ADDR_BITS-1:0] a, input logic [7:0] off);
        return a == C_ADDR_BITS'(off);
    endfunction

    // ---- AXI write channel ----
    always_ff @(posedge aclk) begin
        if (!aresetn) wstate <= WRIDLE;
        else          wstate <= wstate_next;
    end

    always_comb begin
        wstate_next = wstate;
        unique case (wstate)
            WRIDLE:  if (s_axi_awvalid) wstate_next = WRDATA;
            WRDATA:  if (s_axi_wvalid)  wstate_next = WRRESP;
            WRRESP:  if (s_axi_bready)  wstate_next = WRIDLE;
            default: wstate_next = WRIDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = (wstate == WRIDLE);
        s_axi_wready  = (wstate == WRDATA);
        s_axi_bvalid  = (wstate == WRRESP);
    end

    assign s_axi_bresp = 2'b00;

    always_ff @(posedge aclk) begin
        if (wstate == WRIDLE && s_axi_awvalid) waddr <= s_axi_awaddr[C_ADDR_BITS-1:0];
    end

    assign wr_en     = (wstate == WRDATA) && s_axi_wvalid;
    assign sel_ctrl  = wr_en && hit(waddr, ADDR_CTRL) && s_axi_wstrb[0];
    assign start_req = sel_ctrl && s_axi_wdata[CTRL_START_BIT];
    assign abort_req = sel_ctrl && s_axi_wdata[CTRL_ABORT_BIT];
    assign do_start  = start_req && !abort_req;
    assign clr_done  = wr_en && hit(waddr, ADDR_STATUS) && s_axi_wstrb[0] && s_axi_wdata[STAT_DONE_BIT];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cfg_target <= 8'(C_RESET_DUTY);
            cfg_step   <= 8'd1;
            cfg_period <= 16'd0;
        end else if (wr_en) begin
            if (hit(waddr, ADDR_TARGET) && s_axi_wstrb[0]) cfg_target       <= s_axi_wdata[7:0];
            if (hit(waddr, ADDR_STEP)   && s_axi_wstrb[0]) cfg_step         <= s_axi_wdata[7:0];
            if (hit(waddr, ADDR_PERIOD) && s_axi_wstrb[0]) cfg_period[7:0]  <= s_axi_wdata[7:0];
            if (hit(waddr, ADDR_PERIOD) && s_axi_wstrb[1]) cfg_period[15:8] <= s_axi_wdata[15:8];
        end
    end

    // ---- AXI read channel ----
    always_ff @(posedge aclk) begin
        if (!aresetn) rstate <= RDIDLE;
        else          rstate <= rstate_next;
    end

    always_comb begin
        rstate_next = rstate;
        unique case (rstate)
            RDIDLE:  if (s_axi_arvalid) rstate_next = RDDATA;
            RDDATA:  if (s_axi_rready)  rstate_next = RDIDLE;
            default: rstate_next = RDIDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (rstate == RDIDLE);
        s_axi_rvalid  = (rstate == RDDATA);
    end

    assign s_axi_rresp = 2'b00;
    assign raddr       = s_axi_araddr[C_ADDR_BITS-1:0];

    always_comb begin
        rd_mux = '0;
        if (hit(raddr, ADDR_CTRL)) begin
`ifdef PWM_RAMP_IRQ_EN
            rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
`endif
        end else if (hit(raddr, ADDR_TARGET)) begin
            rd_mux[7:0] = cfg_target;
        end else if (hit(raddr, ADDR_STEP)) begin
            rd_mux[7:0] = cfg_step;
        end else if (hit(raddr, ADDR_PERIOD)) begin
            rd_mux[15:0] = cfg_period;
        end else if (hit(raddr, ADDR_STATUS)) begin
            rd_mux[STAT_BUSY_BIT]            = busy;
            rd_mux[STAT_DONE_BIT]            = done;
            rd_mux[STAT_DUTY_LSB +: 8]       = duty;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn)                                s_axi_rdata <= 32'd0;
        else if (rstate == RDIDLE && s_axi_arvalid)  s_axi_rdata <= rd_mux;
    end

    // ---- ramp sequencer ----
    assign duty_stepped = step_toward(duty, lat_target, lat_step);

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort_req) begin
            state_next = IDLE;
        end else if (start_req) begin
            state_next = WAIT;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                WAIT:    if (presc == 16'd0) state_next = STEP;
                STEP:    state_next = (duty_stepped == lat_target) ? IDLE : WAIT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        step_fire = (state == STEP) && !start_req && !abort_req;
        done_set  = step_fire && (duty_stepped == lat_target);
    end

    // Latched ramp parameters and prescaler only matter once a start has loaded them.
    always_ff @(posedge aclk) begin
        if (do_start) begin
            lat_target <= cfg_target;
            lat_step   <= cfg_step;
            lat_period <= cfg_period;
            presc      <= cfg_period;
        end else if (state == WAIT && presc != 16'd0) begin
            presc <= presc - 16'd1;
        end else if (state == STEP) begin
            presc <= lat_period;
        end
    end

    // A done set in the same cycle as a W1C wins so the completion is not lost.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            duty <= 8'(C_RESET_DUTY);
            done <= 1'b0;
        end else begin
            if (step_fire) duty <= duty_stepped;
            if (done_set)      done <= 1'b1;
            else if (clr_done) done <= 1'b0;
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    always_ff @(posedge aclk) begin
        if (!aresetn)      irq_en <= 1'b0;
        else if (sel_ctrl) irq_en <= s_axi_wdata[CTRL_IRQ_EN_BIT];
    end

    assign irq = done & irq_en;
`else
    assign irq = 1'b0;
`endif

    pwm_core u_pwm (
        .clk       (aclk),
        .rst_n     (aresetn),
        .pwm_value (duty),
        .pwm_out   (pwm_out)
    );

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter C_ADDR_BITS, default 8, giving the decoded AXI address width.
REQ-002 The block SHALL have parameter C_RESET_DUTY, default 50, giving the duty value after reset.
REQ-003 The block SHALL have these ports: aclk  in  1  clock; aresetn  in  1  reset, synchronous, active-low.
REQ-004 The block SHALL have an AXI4-lite write address channel: s_axi_awaddr in 32, s_axi_awvalid in 1, s_axi_awready out 1.
REQ-005 The block SHALL have AXI4-lite write data and response channels: s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1, s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1.
REQ-006 The block SHALL have AXI4-lite read channels: s_axi_araddr in 32, s_axi_arvalid in 1, s_axi_arready out 1, s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1.
REQ-007 The block SHALL have these outputs: pwm_out  out 1  PWM waveform; irq  out 1  ramp-done interrupt, level.

Function
REQ-008 AXI write FSM: WRIDLE -> WRDATA on awvalid, WRDATA -> WRRESP on wvalid, WRRESP -> WRIDLE on bready; awready = WRIDLE, wready = WRDATA, bvalid = WRRESP; bresp = 00.
REQ-009 AXI read FSM: RDIDLE -> RDDATA on arvalid, RDDATA -> RDIDLE on rready; arready = RDIDLE, rvalid = RDDATA; rdata is captured on the ar handshake; rresp = 00.
REQ-010 Register map: 0x00 CTRL (bit0 start, bit1 abort; write-only pulses, read 0); 0x04 TARGET[7:0]; 0x08 STEP[7:0]; 0x0C PERIOD[15:0]; 0x10 STATUS (bit0 busy, bit1 done sticky W1C, bits[15:8] current duty).
REQ-011 Reads of unmapped addresses SHALL return 0, and writes to them SHALL be ignored with OKAY; unused high bits read 0.
REQ-012 Ramp FSM states: IDLE, WAIT, STEP; busy = (state != IDLE).
REQ-013 A start write SHALL latch TARGET, STEP and PERIOD, load the prescaler with PERIOD, and enter WAIT on the next cycle, from any state.
REQ-014 WAIT SHALL last PERIOD+1 cycles, decrementing the prescaler and going to STEP when it reaches 0.
REQ-015 STEP SHALL last one cycle and move the duty toward the latched target by min(step, |target-duty|), with no wrap; STEP = 0 is treated as 1.
REQ-016 After STEP, if duty equals the target the FSM SHALL go to IDLE and set done; otherwise it SHALL reload the prescaler and return to WAIT; the duty updates every PERIOD+2 cycles.
REQ-017 A start with target equal to the current duty SHALL still pass through WAIT and STEP, then set done with the duty unchanged.
REQ-018 Abort SHALL go to IDLE the next cycle with the duty held; abort wins over a start in the same write.
REQ-019 Writes to TARGET, STEP or PERIOD during a ramp SHALL not affect the active ramp.
REQ-020 A W1C write to done that coincides with a done set SHALL leave done set.
REQ-021 The duty register SHALL drive pwm_value of the PWM sub-module, which produces pwm_out.

Reset
REQ-022 On reset: both AXI FSMs idle, rdata 0, ramp FSM IDLE, duty = C_RESET_DUTY, TARGET = C_RESET_DUTY, STEP = 1, PERIOD = 0, done 0, irq 0.
REQ-023 Reset during a ramp SHALL abandon the ramp immediately, with no done set.

Configuration
REQ-024 With PWM_RAMP_IRQ_EN defined, irq SHALL equal the done bit AND CTRL bit2 (irq enable, readable at 0x00 bit2); without it, irq SHALL be tied to 0, CTRL bit2 SHALL read 0, and the irq logic SHALL be absent.

Structure
REQ-025 Register offsets, CTRL/STATUS bit positions and FSM state encodings SHALL live in the shared package pwm_pkg.
REQ-026 The single sub-module SHALL be the existing pwm_core (clk, rst_n, pwm_value[7:0], pwm_out); no other sub-modules.

Verification
REQ-027 Reset, then read 0x10 -> 0x00003200 (duty 50, idle, done 0).
REQ-028 TARGET = 60, STEP = 4, PERIOD = 3, start -> duty 54, 58, 60 at 5-cycle spacing, then busy 0 and done 1.
REQ-029 TARGET = 0, STEP = 200 from duty 50 -> one step to 0 with no wrap, then done.
REQ-030 Start a ramp to 200 with STEP = 1, then abort after 3 steps -> duty 53 held, busy 0, done 0.
REQ-031 Write 0x7 to CTRL (start, abort, irq enable together) -> FSM stays IDLE and irq stays 0; then a start alone ramps to done and irq = 1 (macro on); W1C of done -> irq = 0.
REQ-032 Hold bready and rready low for 10 cycles -> bvalid and rvalid stay high, and no second transaction is accepted.
